// File: rtl/imm_packer_if.sv
// Request/response bundle for imm_packer: field-level encode request in, encoded instruction beats out.
// slave is the packer's view, master is the requester/consumer's view.
interface imm_packer_if;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [31:0] in_imm;
   logic        in_li;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_last;
   logic        out_err;

   modport slave (
      input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, in_li, out_ready,
      output in_ready, out_valid, out_instr, out_last, out_err
   );

   modport master (
      output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, in_li, out_ready,
      input  in_ready, out_valid, out_instr, out_last, out_err
   );
endinterface

// File: rtl/imm_packer.sv
// RV32 immediate packer: one-cycle registered encode, outputs held under backpressure.
// Define LI_EXPAND_EN to enable load-immediate expansion into ADDI / LUI / LUI+ADDI beats.
module imm_packer (
   input  logic       clock,
   input  logic       reset,
   imm_packer_if.slave bus
);
   localparam logic [6:0] OP_I_COMP  = 7'b0010011;
   localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_I_JALR  = 7'b1100111;
   localparam logic [6:0] OP_I_ENV   = 7'b1110011;
   localparam logic [6:0] OP_S       = 7'b0100011;
   localparam logic [6:0] OP_B       = 7'b1100011;
   localparam logic [6:0] OP_J       = 7'b1101111;
   localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_U_LUI   = 7'b0110111;

`ifdef LI_EXPAND_EN
   typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, HOLD2 = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1} state_t;
`endif

   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic        two_beat;
   logic        load_beat2;
   logic [31:0] enc_instr;
   logic        enc_err;
   logic [31:0] beat1_instr;
   logic        beat1_err;
   logic [31:0] out_instr_q;
   logic        out_last_q;
   logic        out_err_q;

   logic [31:0] imm;
   logic        sext12_ok;
   logic        sext13_ok;
   logic        sext21_ok;

   assign imm       = bus.in_imm;
   assign sext12_ok = (&imm[31:11]) || !(|imm[31:11]);
   assign sext13_ok = (&imm[31:12]) || !(|imm[31:12]);
   assign sext21_ok = (&imm[31:20]) || !(|imm[31:20]);

   // Format encoder; out-of-range immediates still produce the truncated encoding.
   always_comb begin
      enc_instr = {25'd0, bus.in_opcode};
      enc_err   = 1'b1;
      case (bus.in_opcode)
         OP_I_COMP, OP_I_LOAD, OP_I_JALR: begin
            enc_instr = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            enc_err   = !sext12_ok;
         end
         OP_S: begin
            enc_instr = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode};
            enc_err   = !sext12_ok;
         end
         OP_B: begin
            enc_instr = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         imm[4:1], imm[11], bus.in_opcode};
            enc_err   = !sext13_ok || imm[0];
         end
         OP_J: begin
            enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
            enc_err   = !sext21_ok || imm[0];
         end
         OP_U_AUIPC, OP_U_LUI: begin
            enc_instr = {imm[31:12], bus.in_rd, bus.in_opcode};
            enc_err   = |imm[11:0];
         end
         OP_I_ENV: begin
            enc_instr = {imm[31:20], imm[4:0], bus.in_funct3, bus.in_rd, bus.in_opcode};
            enc_err   = |imm[19:5];
         end
         default: begin
            enc_instr = {25'd0, bus.in_opcode};
            enc_err   = 1'b1;
         end
      endcase
   end

`ifdef LI_EXPAND_EN
   logic        pending2;
   logic        li_small;
   logic        li_lui_only;
   logic [31:0] li_sum;
   logic [31:0] beat2_instr;
   logic [31:0] beat2_q;

   // hi is rounded so that the sign-extended ADDI low part lands on the exact value.
   assign li_small    = sext12_ok;
   assign li_lui_only = (imm[11:0] == 12'd0);
   assign li_sum      = imm + 32'h0000_0800;
   assign beat2_instr = {imm[11:0], bus.in_rd, 3'b000, bus.in_rd, OP_I_COMP};

   always_comb begin
      beat1_instr = enc_instr;
      beat1_err   = enc_err;
      two_beat    = 1'b0;
      if (bus.in_li) begin
         beat1_err = 1'b0;
         if (li_small) begin
            beat1_instr = {imm[11:0], 5'd0, 3'b000, bus.in_rd, OP_I_COMP};
         end else if (li_lui_only) begin
            beat1_instr = {imm[31:12], bus.in_rd, OP_U_LUI};
         end else begin
            beat1_instr = {li_sum[31:12], bus.in_rd, OP_U_LUI};
            two_beat    = 1'b1;
         end
      end
   end
`else
   logic unused_li;

   assign unused_li   = bus.in_li;
   assign beat1_instr = enc_instr;
   assign beat1_err   = enc_err;
   assign two_beat    = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = two_beat ? state_t'(2'd2) : HOLD;
         end
         HOLD: begin
            if (accept)             state_nxt = two_beat ? state_t'(2'd2) : HOLD;
            else if (bus.out_ready) state_nxt = IDLE;
         end
`ifdef LI_EXPAND_EN
         HOLD2: begin
            if (bus.out_ready) state_nxt = HOLD;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.out_valid = (state != IDLE);
`ifdef LI_EXPAND_EN
      pending2      = (state == HOLD2);
      bus.in_ready  = !pending2 && (!bus.out_valid || bus.out_ready);
      load_beat2    = pending2 && bus.out_ready;
`else
      bus.in_ready  = !bus.out_valid || bus.out_ready;
      load_beat2    = 1'b0;
`endif
      accept        = bus.in_valid && bus.in_ready;
      bus.out_instr = out_instr_q;
      bus.out_last  = out_last_q;
      bus.out_err   = out_err_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_instr_q <= 32'd0;
         out_last_q  <= 1'b0;
         out_err_q   <= 1'b0;
`ifdef LI_EXPAND_EN
         beat2_q     <= 32'd0;
`endif
      end else if (accept) begin
         out_instr_q <= beat1_instr;
         out_last_q  <= !two_beat;
         out_err_q   <= beat1_err;
`ifdef LI_EXPAND_EN
         beat2_q     <= beat2_instr;
`endif
      end else if (load_beat2) begin
`ifdef LI_EXPAND_EN
         out_instr_q <= beat2_q;
`endif
         out_last_q  <= 1'b1;
         out_err_q   <= 1'b0;
      end
   end
endmodule
